veririsc_loader: RTL and testbench
==================================

# veririsc_loader

Byte-stream program loader that sits directly upstream of the VeriRISC processor top. It receives a framed image (length, payload, checksum) over a valid/ready byte interface and writes the payload into the processor's 32x8 memory starting at address 0. It holds the CPU in reset while loading, then releases it once the checksum verifies. It reports completion when the CPU asserts halt.

## Interface
- AWIDTH, 5, memory address width; the image holds at most 2**AWIDTH bytes.
- DWIDTH, 8, data and byte width.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a new load.
- in_valid  in  1  input byte valid.
- in_data  in  DWIDTH  input byte.
- in_ready  out  1  loader accepts a byte when in_valid && in_ready.
- mem_wr  out  1  memory write strobe, one cycle per payload byte.
- mem_addr  out  AWIDTH  memory write address.
- mem_data  out  DWIDTH  memory write data.
- cpu_hold  out  1  high keeps the processor in reset.
- cpu_halt  in  1  halt output of the processor.
- done  out  1  high once the CPU has halted after a good load; sticky.
- err  out  1  high on a framing or checksum error; sticky.

## Operation
- FSM states: IDLE, LEN, DATA, CSUM, RUN, HALTED, ERR.
- IDLE:
  - in_ready=0, cpu_hold=1.
  - start → LEN; clears count, sum, done and err.
- LEN:
  - in_ready=1. The accepted byte is N.
  - N==0 or N>2**AWIDTH → ERR. Otherwise store N and sum=N → DATA.
- DATA:
  - in_ready=1. Each accepted byte is written to address count; count increments and sum+=byte.
  - After the N-th byte → CSUM.
- CSUM:
  - in_ready=1. Accept one byte c.
  - (sum+c) mod 2**DWIDTH == 0 → RUN; else → ERR.
- RUN:
  - cpu_hold=0, in_ready=0.
  - cpu_halt → HALTED.
- HALTED: done=1, cpu_hold=1.
- ERR: err=1, cpu_hold=1, in_ready=0.
- start is honoured only in IDLE, RUN, HALTED and ERR; each of these goes to LEN with cpu_hold=1 and done=err=0. In LEN, DATA and CSUM, start is ignored.
- Arithmetic:
  - sum is DWIDTH bits and wraps.
  - count is AWIDTH+1 bits, so N=32 is representable.
  - mem_addr is count[AWIDTH-1:0].
- Input bytes presented while in_ready=0 are not consumed.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, mem_wr=0, mem_addr=0, mem_data=0, cpu_hold=1, done=0, err=0. State returns to IDLE.
- Reset mid-load aborts immediately. Memory contents are undefined, and cpu_hold is already 1.
- start is sampled at cycle t; in_ready=1 from t+1.
- A payload byte accepted at cycle t produces mem_wr=1, with mem_addr and mem_data valid, during t+1 only.
- Back-to-back acceptance is allowed every cycle, giving back-to-back writes.
- The last payload byte is accepted at t; in CSUM, in_ready stays 1 with no bubble.
- A good checksum accepted at t drops cpu_hold at t+1.
- cpu_halt sampled high at t → done=1 and cpu_hold=1 at t+1.
- The error decision is made on the accepting edge; err=1 and in_ready=0 from the next cycle.
- in_ready depends on state only, never on in_valid.

## Structure
- Shared package veririsc_pkg holds:
  - the loader state enum;
  - AWIDTH and DWIDTH defaults, matching the processor localparams;
  - the MAX_IMAGE constant 2**AWIDTH.
- One natural sub-module: loader_checksum, an accumulator with clear/add/zero-check (clr, add, byte in, sum out, is_zero).
- The rest is a single FSM plus the count/address register.

## Test plan
- Good image: start, then bytes 03, A0, 21, E0, checksum 5C → writes A0@0, 21@1, E0@2 on consecutive cycles. cpu_hold falls one cycle after 5C is accepted. Pulse cpu_halt → done=1, cpu_hold=1.
- Bad checksum: same image with checksum 5D → no further writes after the payload, err=1, cpu_hold stays 1, done=0. A new start then clears err and the load succeeds.
- Length bounds: N=00 → err; N=21 (33) → err, with no mem_wr. N=20 (32) with 32 bytes → last write at addr 1F, then CSUM accepted.
- Backpressure/gaps: in_valid toggles randomly across a 5-byte image → exactly 5 writes at addresses 0..4 in order, with correct data.
- Restart: start pulsed during DATA is ignored and the load completes. start pulsed in RUN → cpu_hold=1 next cycle and the state returns to LEN.
- Reset mid-load: assert rst during DATA → all outputs at their reset values asynchronously, cpu_hold=1. After release, a full good load completes.

Source files
------------

// File: rtl/veririsc_pkg.sv
// Shared VeriRISC definitions: memory geometry defaults and loader state encoding.
package veririsc_pkg;

   localparam int unsigned DEF_AWIDTH = 5;
   localparam int unsigned DEF_DWIDTH = 8;
   localparam int unsigned MAX_IMAGE  = 2 ** DEF_AWIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_RUN,
      S_HALTED,
      S_ERR
   } loader_state_t;

endpackage

// File: rtl/loader_checksum.sv
// Modulo-2**DWIDTH byte accumulator; is_zero_c tells whether adding byte_in would land on zero.
module loader_checksum
   import veririsc_pkg::*;
#(
   parameter int unsigned DWIDTH = DEF_DWIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              add,
   input  logic [DWIDTH-1:0] byte_in,
   output logic              is_zero_c
);

   logic [DWIDTH-1:0] sum;
   logic [DWIDTH-1:0] total_c;

   assign total_c   = sum + byte_in;
   assign is_zero_c = (total_c == '0);

   // clr together with add seeds the accumulator with byte_in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= '0;
      end else if (clr) begin
         sum <= add ? byte_in : '0;
      end else if (add) begin
         sum <= total_c;
      end
   end

endmodule

// File: rtl/veririsc_loader.sv
// Framed byte-stream loader: length, payload, checksum into CPU memory, then runs the CPU.
module veririsc_loader
   import veririsc_pkg::*;
#(
   parameter int unsigned AWIDTH = DEF_AWIDTH,
   parameter int unsigned DWIDTH = DEF_DWIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_ready,
   output logic              mem_wr,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_data,
   output logic              cpu_hold,
   input  logic              cpu_halt,
   output logic              done,
   output logic              err
);

   localparam int unsigned CW    = AWIDTH + 1;
   localparam int unsigned MAX_N = 2 ** AWIDTH;

   loader_state_t state;
   logic [CW-1:0] count;
   logic [CW-1:0] len;

   logic          accept_c;
   logic          start_ok_c;
   logic          len_bad_c;
   logic          sum_clr_c;
   logic          sum_add_c;
   logic          csum_ok_c;
   logic [CW-1:0] count_inc_c;

   assign accept_c    = in_valid && in_ready;
   assign start_ok_c  = start && (state == S_IDLE || state == S_RUN ||
                                  state == S_HALTED || state == S_ERR);
   assign len_bad_c   = (in_data == '0) || (32'(in_data) > MAX_N);
   assign count_inc_c = count + CW'(1);
   assign sum_clr_c   = start_ok_c || (state == S_LEN && accept_c);
   assign sum_add_c   = accept_c && (state == S_LEN || state == S_DATA);

   loader_checksum #(.DWIDTH(DWIDTH)) u_checksum (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (sum_clr_c),
      .add       (sum_add_c),
      .byte_in   (in_data),
      .is_zero_c (csum_ok_c)
   );

   // Loader FSM with registered handshake, memory and CPU control outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         count    <= '0;
         len      <= '0;
         in_ready <= 1'b0;
         mem_wr   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         mem_wr <= 1'b0;
         if (start_ok_c) begin
            state    <= S_LEN;
            count    <= '0;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
         end else begin
            case (state)
               S_LEN: begin
                  if (accept_c) begin
                     if (len_bad_c) begin
                        state    <= S_ERR;
                        err      <= 1'b1;
                        in_ready <= 1'b0;
                     end else begin
                        len   <= CW'(in_data);
                        state <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (accept_c) begin
                     mem_wr   <= 1'b1;
                     mem_addr <= count[AWIDTH-1:0];
                     mem_data <= in_data;
                     count    <= count_inc_c;
                     if (count_inc_c == len) begin
                        state <= S_CSUM;
                     end
                  end
               end
               S_CSUM: begin
                  if (accept_c) begin
                     in_ready <= 1'b0;
                     if (csum_ok_c) begin
                        state    <= S_RUN;
                        cpu_hold <= 1'b0;
                     end else begin
                        state <= S_ERR;
                        err   <= 1'b1;
                     end
                  end
               end
               S_RUN: begin
                  if (cpu_halt) begin
                     state    <= S_HALTED;
                     done     <= 1'b1;
                     cpu_hold <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_veririsc_loader.sv
// Self-checking bench for veririsc_loader; memory writes are checked against a queue of expected (addr, data).
module tb_veririsc_loader;
   import veririsc_pkg::*;

   localparam int unsigned AW = DEF_AWIDTH;
   localparam int unsigned DW = DEF_DWIDTH;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          cpu_hold;
   logic          cpu_halt;
   logic          done;
   logic          err;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [AW+DW-1:0] exp_q[$];
   logic [DW-1:0]    img[MAX_IMAGE];

   veririsc_loader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .mem_wr   (mem_wr),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .cpu_hold (cpu_hold),
      .cpu_halt (cpu_halt),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Scoreboard: every write must match the oldest expected entry
   always @(posedge clk) begin
      #1;
      if (mem_wr === 1'b1) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_write addr=%0h data=%02h", mem_addr, mem_data);
         end else begin
            logic [AW+DW-1:0] e;
            e = exp_q.pop_front();
            if ({mem_addr, mem_data} !== e) begin
               tests_failed++;
               $display("FAIL write got addr=%0h data=%02h exp addr=%0h data=%02h",
                        mem_addr, mem_data, e[AW+DW-1:DW], e[DW-1:0]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_halt();
      cpu_halt = 1'b1;
      tick();
      cpu_halt = 1'b0;
   endtask

   task automatic send_byte(input logic [DW-1:0] b, input bit is_payload, input logic [AW-1:0] addr);
      bit acc = 1'b0;
      if (is_payload) exp_q.push_back({addr, b});
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 50 && !acc; i++) begin
         acc = in_ready;
         tick();
      end
      in_valid = 1'b0;
      if (!acc) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_timeout byte=%02h got=no_accept exp=accept", b);
      end
   endtask

   task automatic load_image(input int n, input int max_gap);
      logic [DW-1:0] sum;
      sum = DW'(n);
      send_byte(DW'(n), 1'b0, '0);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, max_gap)) tick();
         send_byte(img[i], 1'b1, AW'(i));
         sum = sum + img[i];
      end
      send_byte(DW'(0) - sum, 1'b0, '0);
   endtask

   task automatic test_reset();
      tests_run++;
      if ({in_ready, mem_wr, mem_addr, mem_data, cpu_hold, done, err} !== {1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_values got=%b exp=%b",
                  {in_ready, mem_wr, mem_addr, mem_data, cpu_hold, done, err},
                  {1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0});
      end
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1;
      in_data  = 8'h55;
      tick();
      tick();
      tests_run++;
      if (in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_in_ready got=%b exp=0", in_ready);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_good_image();
      pulse_start();
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL good_ready_after_start got=%b exp=1", in_ready);
      end
      send_byte(8'h03, 1'b0, '0);
      send_byte(8'hA0, 1'b1, 5'd0);
      send_byte(8'h21, 1'b1, 5'd1);
      send_byte(8'hE0, 1'b1, 5'd2);
      tests_run++;
      if ({in_ready, cpu_hold} !== 2'b11) begin
         tests_failed++;
         $display("FAIL good_csum_ready got=%b exp=11", {in_ready, cpu_hold});
      end
      send_byte(8'h5C, 1'b0, '0);
      tests_run++;
      if ({cpu_hold, in_ready, done, err} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL good_release got=%b exp=0000", {cpu_hold, in_ready, done, err});
      end
      tick();
      tick();
      pulse_halt();
      tests_run++;
      if ({done, cpu_hold} !== 2'b11) begin
         tests_failed++;
         $display("FAIL good_halt got=%b exp=11", {done, cpu_hold});
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL good_pending got=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_bad_checksum();
      pulse_start();
      send_byte(8'h03, 1'b0, '0);
      send_byte(8'hA0, 1'b1, 5'd0);
      send_byte(8'h21, 1'b1, 5'd1);
      send_byte(8'hE0, 1'b1, 5'd2);
      send_byte(8'h5D, 1'b0, '0);
      tests_run++;
      if ({err, cpu_hold, done, in_ready} !== 4'b1100) begin
         tests_failed++;
         $display("FAIL bad_csum got=%b exp=1100", {err, cpu_hold, done, in_ready});
      end
      repeat (3) tick();
      pulse_start();
      tests_run++;
      if ({err, in_ready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL bad_restart got=%b exp=01", {err, in_ready});
      end
      img[0] = 8'hA0;
      img[1] = 8'h21;
      img[2] = 8'hE0;
      load_image(3, 0);
      tests_run++;
      if ({cpu_hold, err} !== 2'b00) begin
         tests_failed++;
         $display("FAIL bad_reload got=%b exp=00", {cpu_hold, err});
      end
      pulse_halt();
      tests_run++;
      if (done !== 1'b1) begin
         tests_failed++;
         $display("FAIL bad_reload_done got=%b exp=1", done);
      end
   endtask

   task automatic test_len_bounds();
      logic [DW-1:0] sum;
      pulse_start();
      send_byte(8'h00, 1'b0, '0);
      tests_run++;
      if ({err, in_ready, cpu_hold} !== 3'b101) begin
         tests_failed++;
         $display("FAIL len_zero got=%b exp=101", {err, in_ready, cpu_hold});
      end
      pulse_start();
      send_byte(8'h21, 1'b0, '0);
      tests_run++;
      if ({err, in_ready, cpu_hold} !== 3'b101) begin
         tests_failed++;
         $display("FAIL len_33 got=%b exp=101", {err, in_ready, cpu_hold});
      end
      tick();
      pulse_start();
      sum = 8'h20;
      send_byte(8'h20, 1'b0, '0);
      for (int i = 0; i < 32; i++) begin
         img[i] = DW'($urandom_range(0, 255));
         send_byte(img[i], 1'b1, AW'(i));
         sum = sum + img[i];
      end
      tests_run++;
      if ({in_ready, err} !== 2'b10) begin
         tests_failed++;
         $display("FAIL len_32_csum_ready got=%b exp=10", {in_ready, err});
      end
      send_byte(DW'(0) - sum, 1'b0, '0);
      tests_run++;
      if ({cpu_hold, err} !== 2'b00) begin
         tests_failed++;
         $display("FAIL len_32_run got=%b exp=00", {cpu_hold, err});
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL len_32_pending got=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      pulse_start();
      for (int i = 0; i < 5; i++) img[i] = DW'($urandom_range(0, 255));
      load_image(5, 3);
      tests_run++;
      if ({cpu_hold, err, exp_q.size() == 0} !== 3'b001) begin
         tests_failed++;
         $display("FAIL gaps_result got=%b exp=001", {cpu_hold, err, exp_q.size() == 0});
      end
      in_valid = 1'b1;
      in_data  = 8'h77;
      repeat (4) tick();
      tests_run++;
      if ({in_ready, cpu_hold} !== 2'b00) begin
         tests_failed++;
         $display("FAIL run_no_consume got=%b exp=00", {in_ready, cpu_hold});
      end
      in_valid = 1'b0;
   endtask

   task automatic test_restart();
      pulse_start();
      send_byte(8'h03, 1'b0, '0);
      send_byte(8'hA0, 1'b1, 5'd0);
      pulse_start();
      send_byte(8'h21, 1'b1, 5'd1);
      send_byte(8'hE0, 1'b1, 5'd2);
      send_byte(8'h5C, 1'b0, '0);
      tests_run++;
      if ({cpu_hold, err} !== 2'b00) begin
         tests_failed++;
         $display("FAIL restart_data_ignored got=%b exp=00", {cpu_hold, err});
      end
      tick();
      pulse_start();
      tests_run++;
      if ({cpu_hold, in_ready, done} !== 3'b110) begin
         tests_failed++;
         $display("FAIL restart_in_run got=%b exp=110", {cpu_hold, in_ready, done});
      end
      send_byte(8'h00, 1'b0, '0);
      tests_run++;
      if (err !== 1'b1) begin
         tests_failed++;
         $display("FAIL restart_is_len got=%b exp=1", err);
      end
   endtask

   task automatic test_reset_midload();
      pulse_start();
      send_byte(8'h03, 1'b0, '0);
      send_byte(8'hA0, 1'b1, 5'd0);
      send_byte(8'h21, 1'b1, 5'd1);
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({in_ready, mem_wr, mem_addr, mem_data, cpu_hold, done, err} !== {1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL midload_reset got=%b exp=%b",
                  {in_ready, mem_wr, mem_addr, mem_data, cpu_hold, done, err},
                  {1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0});
      end
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      pulse_start();
      for (int i = 0; i < 4; i++) img[i] = DW'($urandom_range(0, 255));
      load_image(4, 1);
      tests_run++;
      if ({cpu_hold, err} !== 2'b00) begin
         tests_failed++;
         $display("FAIL midload_reload got=%b exp=00", {cpu_hold, err});
      end
      pulse_halt();
      tests_run++;
      if ({done, cpu_hold, exp_q.size() == 0} !== 3'b111) begin
         tests_failed++;
         $display("FAIL midload_done got=%b exp=111", {done, cpu_hold, exp_q.size() == 0});
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      cpu_halt = 1'b0;
      #12;
      test_reset();
      test_good_image();
      test_bad_checksum();
      test_len_bounds();
      test_backpressure();
      test_restart();
      test_reset_midload();
      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
